// File: rtl/md_unit_pkg.sv
// Shared CPU control-code constants for the multiply/divide unit:
// md_op encodings, FSM states and default latencies.
package md_unit_pkg;

    localparam int XLEN               = 32;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit: operands latched at launch, result
// computed combinationally from the latched copy and committed on the last busy edge.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic             busy,
    output logic [XLEN-1:0]  hi,
    output logic [XLEN-1:0]  lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAXC_SAFE()) : 1;

    function automatic int MAXC_SAFE();
        return MAX_CYCLES;
    endfunction

    // Low 64 bits of the product of the 64-bit extended operands are correct
    // for both the signed and unsigned interpretation.
    function automatic logic [2*XLEN-1:0] mul_64(input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y,
                                                 input logic            sgn);
        logic signed [2*XLEN-1:0] xs;
        logic signed [2*XLEN-1:0] ys;
        logic signed [2*XLEN-1:0] p;
        xs = sgn ? {{XLEN{x[XLEN-1]}}, x} : {{XLEN{1'b0}}, x};
        ys = sgn ? {{XLEN{y[XLEN-1]}}, y} : {{XLEN{1'b0}}, y};
        p  = xs * ys;
        return p;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so
    // 0x80000000 / -1 wraps back to 0x80000000 with no overflow special case.
    function automatic logic [2*XLEN-1:0] div_64(input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y,
                                                 input logic            sgn);
        logic [XLEN-1:0] xm;
        logic [XLEN-1:0] ym;
        logic [XLEN-1:0] qm;
        logic [XLEN-1:0] rm;
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        xm = (sgn && x[XLEN-1]) ? -x : x;
        ym = (sgn && y[XLEN-1]) ? -y : y;
        if (ym == '0) begin
            qm = '0;
            rm = '0;
        end else begin
            qm = xm / ym;
            rm = xm % ym;
        end
        q = (sgn && (x[XLEN-1] ^ y[XLEN-1])) ? -qm : qm;
        r = (sgn && x[XLEN-1]) ? -rm : rm;
        return {r, q};
    endfunction

    md_state_e        state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN-1:0]  hi_q,     hi_d;
    logic [XLEN-1:0]  lo_q,     lo_d;
    logic [XLEN-1:0]  a_q,      a_d;
    logic [XLEN-1:0]  b_q,      b_d;
    logic             is_div_q, is_div_d;
    logic             is_sgn_q, is_sgn_d;

    logic             op_is_div;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] divres;

    assign op_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign prod      = mul_64(a_q, b_q, is_sgn_q);
    assign divres    = div_64(a_q, b_q, is_sgn_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        is_sgn_d = is_sgn_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            a_d      = a;
                            b_d      = b;
                            is_div_d = op_is_div;
                            is_sgn_d = (md_op == MD_MULT) || (md_op == MD_DIV);
                            cnt_d    = op_is_div ? CNT_W'(DIV_CYCLES - 1)
                                                 : CNT_W'(MULT_CYCLES - 1);
                            state_d  = MD_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod;
                    end else if (b_q != '0) begin
                        {hi_d, lo_d} = divres;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Control and architectural HI/LO state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Launch-time operand copy; only meaningful while RUN
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        is_div_q <= is_div_d;
        is_sgn_q <= is_sgn_d;
    end

    assign busy = (state_q == MD_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed + small random bench for md_unit with a scoreboard of expected HI/LO results.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference behaviour computed with 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h0,
                                          input logic [31:0] l0);
        longint          sp;
        longint          sq;
        longint          sr;
        longint unsigned up;
        logic [63:0]     res;
        res = {h0, l0};
        case (op)
            MD_MULT: begin
                sp  = longint'($signed(x)) * longint'($signed(y));
                res = sp;
            end
            MD_MULTU: begin
                up  = {32'b0, x} * {32'b0, y};
                res = up;
            end
            MD_DIV: if (y != 0) begin
                sp  = longint'($signed(x));
                sq  = sp / longint'($signed(y));
                sr  = sp % longint'($signed(y));
                res = {sr[31:0], sq[31:0]};
            end
            MD_DIVU: if (y != 0) res = {x % y, x / y};
            default: ;
        endcase
        return res;
    endfunction

    // Called at a falling edge; leaves the bench one falling edge later
    task automatic launch(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int   n;
        sb.push_back('{hi: ehi, lo: elo, cycles: cyc});
        launch(op, x, y);
        wait_busy(n);
        e = sb.pop_front();
        chk({tag, " busy_cycles"}, 32'(n), 32'(e.cycles));
        chk({tag, " hi"}, hi, e.hi);
        chk({tag, " lo"}, lo, e.lo);
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    initial begin
        logic [63:0] m;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        exp_t        e;
        int          n;

        reset = 1'b1;
        start = 1'b0;
        md_op = MD_NONE;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b0;
        cur_hi = '0;
        cur_lo = '0;

        run_op("mult", MD_MULT, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        run_op("div", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
        run_op("divu", MD_DIVU, 32'hFFFFFFFF, 32'd2, 10, 32'd1, 32'h7FFFFFFF);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

        start = 1'b1;
        md_op = MD_MTHI;
        a     = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        chk("mthi busy", 32'(busy), 32'd0);
        chk("mthi hi", hi, 32'h12345678);
        chk("mthi lo", lo, cur_lo);
        cur_hi = 32'h12345678;

        run_op("div0", MD_DIV, 32'd5, 32'd0, 10, cur_hi, cur_lo);

        for (int i = 0; i < 4; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom;
            m   = model(rop, ra, rb, cur_hi, cur_lo);
            run_op("random", rop, ra, rb, (rop >= MD_DIV) ? 10 : 5, m[63:32], m[31:0]);
        end

        // Operands and a competing start change during RUN
        sb.push_back('{hi: 32'd0, lo: 32'd12, cycles: 5});
        launch(MD_MULT, 32'd3, 32'd4);
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        start = 1'b1;
        md_op = MD_MTLO;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        wait_busy(n);
        e = sb.pop_front();
        chk("hold busy_cycles", 32'(n + 1), 32'(e.cycles));
        chk("hold hi", hi, e.hi);
        chk("hold lo", lo, e.lo);
        cur_hi = e.hi;
        cur_lo = e.lo;

        start = 1'b1;
        md_op = MD_NONE;
        a     = 32'hDEADBEEF;
        @(negedge clk);
        md_op = MD_RSVD;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        chk("none busy", 32'(busy), 32'd0);
        chk("none hi", hi, cur_hi);
        chk("none lo", lo, cur_lo);

        // Abort by reset mid-run
        launch(MD_MULT, 32'd2, 32'd3);
        @(negedge clk);
        start = 1'b1;
        md_op = MD_MULTU;
        a     = 32'd9;
        b     = 32'd9;
        chk("abort busy_c2", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        reset = 1'b1;
        chk("abort busy_c3", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        repeat (10) @(negedge clk);
        chk("abort later busy", 32'(busy), 32'd0);
        chk("abort later hi", hi, 32'd0);
        chk("abort later lo", lo, 32'd0);
        cur_hi = '0;
        cur_lo = '0;

        // MTLO in the cycle busy falls, then MULT straight after
        run_op("b2b mult1", MD_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);
        start = 1'b1;
        md_op = MD_MTLO;
        a     = 32'hCAFEF00D;
        @(negedge clk);
        chk("b2b mtlo lo", lo, 32'hCAFEF00D);
        chk("b2b mtlo busy", 32'(busy), 32'd0);
        run_op("b2b mult2", MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'd0, 32'd1);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
